mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Load/store unit between the EX/MEM pipeline register and the word-only data memory in the MEM stage. It converts RV32I loads and stores (byte, halfword, word) into word-aligned memory accesses. Sub-word stores become a two-cycle read-modify-write with a pipeline stall. Loads return sign- or zero-extended data one cycle after issue.

Parameters:
ADDR_W, 10, number of valid byte-address bits; any address with a nonzero bit in [31:ADDR_W] faults.

Ports:
i_clk  input  1  clock, all state updates on the rising edge
i_reset_n  input  1  synchronous active-low reset
i_valid  input  1  request present from EX/MEM
i_ctrlMEM  input  2  [1]=mem-read (load), [0]=mem-write (store)
i_funct3  input  3  0=B, 1=H, 2=W, 4=BU, 5=HU; BU/HU are legal for loads only
i_addr  input  32  byte address
i_storeData  input  32  store source (rs2)
o_stall  output  1  combinational; holds the upstream pipeline
o_loadData  output  32  registered, extended load result
o_loadValid  output  1  registered, one-cycle pulse
o_fault  output  1  registered, one-cycle pulse: misaligned or illegal access
o_memAddr  output  32  word-aligned address to the data memory
o_memWriteData  output  32  write data to the data memory
o_memCtrl  output  2  {read, write} to the data memory
i_memReadData  input  32  memory read data; valid at the rising edge that ends a read cycle

Behaviour:
- States: IDLE, RMW_WR.
- Reset (synchronous, i_reset_n=0 at a rising edge):
  - state=IDLE; o_loadData=0, o_loadValid=0, o_fault=0.
  - o_memCtrl=00 while reset is asserted.
  - Reset during RMW_WR abandons the write; memory is not modified.
- Fault check, in IDLE with i_valid=1:
  - i_ctrlMEM=11.
  - funct3 not in {0,1,2,4,5}, or funct3 in {4,5} with a store.
  - H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - addr[31:ADDR_W]!=0.
  - On fault: o_memCtrl=00, no stall, o_fault=1 next cycle, o_loadValid stays 0.
- Idle request: i_valid=0 or i_ctrlMEM=00 -> o_memCtrl=00, no outputs pulse.
- o_memAddr={addr[31:2],2'b00}. In RMW_WR it uses the latched address.
- Load (IDLE, legal):
  - o_memCtrl=10 this cycle.
  - At the ending edge, select the lane from i_memReadData: byte lane = addr[1:0], half lane = addr[1].
  - Extend per funct3 into o_loadData; o_loadValid=1 for the next cycle only.
  - o_stall=0. Latency 1.
- Word store (IDLE, legal): o_memCtrl=01, o_memWriteData=i_storeData, single cycle, o_stall=0.
- Sub-word store (SB/SH, IDLE, legal):
  - Cycle 1: o_memCtrl=10, o_stall=1; latch addr, storeData[15:0], funct3.
  - At the edge: capture i_memReadData, merge the new byte/half into its lane, go to RMW_WR.
  - Cycle 2 (RMW_WR): o_memCtrl=01, o_memWriteData=merged word, o_stall=0, ignore inputs; return to IDLE.
- o_stall is high only in cycle 1 of a sub-word store.
- Upstream holds the same request for exactly one extra cycle. The request presented during RMW_WR is the held copy and is not re-executed.
- o_loadValid and o_fault are never both 1.

Test Plan:
- Reset: hold i_reset_n=0 for 2 edges -> o_loadData=0, o_loadValid=0, o_fault=0, o_memCtrl=00; state is IDLE.
- Word store then word load: SW addr=0x10, data=0xDEADBEEF; next cycle LW addr=0x10 -> o_memCtrl 01 then 10; o_loadData=0xDEADBEEF with o_loadValid pulse 1 cycle after the load.
- Sub-word store: SB addr=0x11, data=0x5A over word 0xDEADBEEF -> o_stall=1 for 1 cycle; RMW_WR writes 0xDEAD5AEF to 0x10.
- Load extension on word 0x80FF7F01 at 0x20:
  - LB 0x21 -> 0x0000007F.
  - LB 0x22 -> 0xFFFFFFFF.
  - LBU 0x22 -> 0x000000FF.
  - LH 0x22 -> 0xFFFF80FF.
  - LHU 0x22 -> 0x000080FF.
- Faults, each -> o_fault pulse, o_memCtrl=00, memory unchanged, o_loadValid=0:
  - LW 0x22.
  - SH 0x23.
  - SW 0x400 (ADDR_W=10).
  - i_ctrlMEM=11.
  - store with funct3=4.
- Reset mid-RMW: SH addr=0x30, data=0x1234 over 0xAAAAAAAA; assert reset during RMW_WR -> no write; a later LW 0x30 returns 0xAAAAAAAA.

Source files
------------

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: adapts RV32I byte/half/word accesses to a word-only data memory.
// Sub-word stores run as a stalled read followed by a merged write (RMW_WR).
module mem_lsu_lane #(
  parameter logic [1:0] LANE = 2'd0
) (
  input  logic [1:0]  i_addrLo,
  input  logic        i_half,
  input  logic [15:0] i_data,
  input  logic [7:0]  i_old,
  output logic [7:0]  o_byte
);
  logic w_hit;
  logic [7:0] w_new;

  assign w_hit  = i_half ? (i_addrLo[1] == LANE[1]) : (i_addrLo == LANE);
  // a halfword puts its low byte in even lanes and its high byte in odd lanes
  assign w_new  = (i_half && LANE[0]) ? i_data[15:8] : i_data[7:0];
  assign o_byte = w_hit ? w_new : i_old;
endmodule

module mem_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [1:0]  i_ctrlMEM,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_storeData,
  output logic        o_stall,
  output logic [31:0] o_loadData,
  output logic        o_loadValid,
  output logic        o_fault,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_memWriteData,
  output logic [1:0]  o_memCtrl,
  input  logic [31:0] i_memReadData
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RMW_WR = 1'b1;

  logic [0:0]  r_state;
  logic [31:2] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_loadData;
  logic        r_loadValid;
  logic        r_fault;

  logic        w_active, w_f3ok, w_misal, w_oob, w_illegal;
  logic        w_fault, w_load, w_store, w_subw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadExt, w_merged;

  assign w_active  = (r_state == S_IDLE) && i_valid && (i_ctrlMEM != 2'b00);
  assign w_f3ok    = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                     (i_funct3 == 3'd4) || (i_funct3 == 3'd5);
  assign w_misal   = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                     ((i_funct3 == 3'd2) && (i_addr[1:0] != 2'b00));
  assign w_oob     = |i_addr[31:ADDR_W];
  // funct3[2] marks the unsigned variants, which have no store form
  assign w_illegal = (i_ctrlMEM == 2'b11) || !w_f3ok || (i_ctrlMEM[0] && i_funct3[2]) ||
                     w_misal || w_oob;
  assign w_fault   = w_active && w_illegal;
  assign w_load    = w_active && !w_illegal && i_ctrlMEM[1];
  assign w_store   = w_active && !w_illegal && i_ctrlMEM[0];
  assign w_subw    = w_store && (i_funct3 != 3'd2);

  assign w_byte = i_memReadData[{i_addr[1:0], 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_memReadData[31:16] : i_memReadData[15:0];

  always_comb begin
    w_loadExt = i_memReadData;
    case (i_funct3)
      3'd0:    w_loadExt = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_loadExt = {{16{w_half[15]}}, w_half};
      3'd4:    w_loadExt = {24'd0, w_byte};
      3'd5:    w_loadExt = {16'd0, w_half};
      default: w_loadExt = i_memReadData;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    mem_lsu_lane #(.LANE(2'(k))) u_lane (
      .i_addrLo (i_addr[1:0]),
      .i_half   (i_funct3[0]),
      .i_data   (i_storeData[15:0]),
      .i_old    (i_memReadData[8*k +: 8]),
      .o_byte   (w_merged[8*k +: 8])
    );
  end

  always_comb begin
    o_memCtrl      = 2'b00;
    o_memAddr      = {i_addr[31:2], 2'b00};
    o_memWriteData = i_storeData;
    o_stall        = 1'b0;
    if (!i_reset_n) begin
      o_memCtrl = 2'b00;
    end else if (r_state == S_RMW_WR) begin
      o_memCtrl      = 2'b01;
      o_memAddr      = {r_addr, 2'b00};
      o_memWriteData = r_wdata;
    end else if (w_load || w_subw) begin
      o_memCtrl = 2'b10;
      o_stall   = w_subw;
    end else if (w_store) begin
      o_memCtrl = 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_loadData  <= 32'd0;
      r_loadValid <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_loadValid <= w_load;
      r_fault     <= w_fault;
      if (w_load) r_loadData <= w_loadExt;
      case (r_state)
        S_IDLE:   if (w_subw) r_state <= S_RMW_WR;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // merge happens at the read edge, so only the finished word needs holding
  always_ff @(posedge i_clk) begin
    if (w_subw) begin
      r_addr  <= i_addr[31:2];
      r_wdata <= w_merged;
    end
  end

  assign o_loadData  = r_loadData;
  assign o_loadValid = r_loadValid;
  assign o_fault     = r_fault;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, reset-during-RMW sequence, then random ops
// checked against a byte-array memory model.
module tb_mem_lsu;
  localparam int ADDR_W = 10;
  localparam int NB = 1 << ADDR_W;
  localparam int NW = NB / 4;

  logic        clk = 1'b0;
  logic        rst_n, valid;
  logic [1:0]  ctrl;
  logic [2:0]  f3;
  logic [31:0] addr, sdata;
  logic        stall, lv, flt;
  logic [31:0] ld, maddr, mwd, mrd;
  logic [1:0]  mctrl;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_ctrlMEM(ctrl), .i_funct3(f3),
    .i_addr(addr), .i_storeData(sdata), .o_stall(stall), .o_loadData(ld),
    .o_loadValid(lv), .o_fault(flt), .o_memAddr(maddr), .o_memWriteData(mwd),
    .o_memCtrl(mctrl), .i_memReadData(mrd)
  );

  logic [31:0] mem [NW];
  logic [7:0]  ref_mem [NB];
  logic        fill;
  int n_tests = 0, n_fail = 0;

  function automatic logic [31:0] ref_word(int b);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  assign mrd = mem[maddr[ADDR_W-1:2]];
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < NW; i++) mem[i] <= ref_word(4*i);
    else if (mctrl == 2'b01) mem[maddr[ADDR_W-1:2]] <= mwd;
  end

  always @(negedge clk) if (rst_n && lv && flt) begin
    n_tests++; n_fail++;
    $display("FAIL excl: loadValid=%0d fault=%0d required not both 1", lv, flt);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int acc_size(logic [2:0] f);
    if (f == 3'd2) return 4;
    if (f == 3'd1 || f == 3'd5) return 2;
    return 1;
  endfunction

  function automatic logic m_fault(logic [1:0] c, logic [2:0] f, logic [31:0] a);
    if (c == 2'b11) return 1'b1;
    if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (c == 2'b01 && f >= 3'd4) return 1'b1;
    if (a % acc_size(f) != 0) return 1'b1;
    if (a >= NB) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f, logic [31:0] a);
    int sz = acc_size(f);
    logic [31:0] w = 0;
    for (int i = 0; i < sz; i++) w |= 32'(ref_mem[a+i]) << (8*i);
    if (f < 3'd4 && sz < 4 && w[8*sz-1]) w |= 32'hFFFF_FFFF << (8*sz);
    return w;
  endfunction

  task automatic m_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < acc_size(f); i++) ref_mem[a+i] = 8'(d >> (8*i));
  endtask

  // one request, including the held repeat cycle when the LSU stalls
  task automatic do_op(input logic v, input logic [1:0] c, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input logic xf,
                       input logic xlv, input logic [31:0] xld, input string nm);
    logic act, is_ld, is_st, sub;
    logic [1:0] xctrl;
    logic [31:0] xw;
    act   = v && (c != 2'b00);
    is_ld = act && !xf && c == 2'b10;
    is_st = act && !xf && c == 2'b01;
    sub   = is_st && f != 3'd2;
    xctrl = (is_ld || sub) ? 2'b10 : is_st ? 2'b01 : 2'b00;
    xw    = 0;
    @(negedge clk);
    valid = v; ctrl = c; f3 = f; addr = a; sdata = d;
    #1;
    chk({nm, ".ctrl"}, 32'(mctrl), 32'(xctrl));
    chk({nm, ".stall"}, 32'(stall), 32'(sub));
    if (xctrl != 2'b00) chk({nm, ".addr"}, maddr, {a[31:2], 2'b00});
    if (is_st && !sub) chk({nm, ".wdata"}, mwd, d);
    if (is_st) begin
      m_store(f, a, d);
      xw = ref_word(int'({a[31:2], 2'b00}));
    end
    @(posedge clk); #1;
    chk({nm, ".fault"}, 32'(flt), 32'(xf));
    chk({nm, ".lvalid"}, 32'(lv), 32'(xlv));
    if (xlv) chk({nm, ".ldata"}, ld, xld);
    if (sub) begin
      chk({nm, ".rmw_ctrl"}, 32'(mctrl), 32'd1);
      chk({nm, ".rmw_stall"}, 32'(stall), 32'd0);
      chk({nm, ".rmw_addr"}, maddr, {a[31:2], 2'b00});
      chk({nm, ".rmw_wdata"}, mwd, xw);
      @(posedge clk); #1;
      chk({nm, ".rmw_pulse"}, {30'd0, lv, flt}, 32'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  c;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    logic        xf;
    logic        xlv;
    logic [31:0] xld;
  } vec_t;

  initial begin
    vec_t tbl [20];
    int bad;
    logic v, xf, xlv;
    logic [1:0] c;
    logic [2:0] f;
    logic [31:0] a, xld;
    int r;

    tbl[0]  = '{2'b01, 3'd2, 32'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{2'b10, 3'd2, 32'h010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[2]  = '{2'b01, 3'd0, 32'h011, 32'h5A,       1'b0, 1'b0, 32'h0};
    tbl[3]  = '{2'b10, 3'd2, 32'h010, 32'h0,        1'b0, 1'b1, 32'hDEAD5AEF};
    tbl[4]  = '{2'b01, 3'd2, 32'h020, 32'h80FF7F01, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{2'b10, 3'd0, 32'h021, 32'h0,        1'b0, 1'b1, 32'h0000007F};
    tbl[6]  = '{2'b10, 3'd0, 32'h022, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[7]  = '{2'b10, 3'd4, 32'h022, 32'h0,        1'b0, 1'b1, 32'h000000FF};
    tbl[8]  = '{2'b10, 3'd1, 32'h022, 32'h0,        1'b0, 1'b1, 32'hFFFF80FF};
    tbl[9]  = '{2'b10, 3'd5, 32'h022, 32'h0,        1'b0, 1'b1, 32'h000080FF};
    tbl[10] = '{2'b10, 3'd2, 32'h022, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[11] = '{2'b01, 3'd1, 32'h023, 32'hFFFF,     1'b1, 1'b0, 32'h0};
    tbl[12] = '{2'b01, 3'd2, 32'h400, 32'h12345678, 1'b1, 1'b0, 32'h0};
    tbl[13] = '{2'b11, 3'd2, 32'h020, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[14] = '{2'b01, 3'd4, 32'h020, 32'h55,       1'b1, 1'b0, 32'h0};
    tbl[15] = '{2'b10, 3'd3, 32'h020, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[16] = '{2'b00, 3'd2, 32'h020, 32'h0,        1'b0, 1'b0, 32'h0};
    tbl[17] = '{2'b10, 3'd2, 32'h020, 32'h0,        1'b0, 1'b1, 32'h80FF7F01};
    tbl[18] = '{2'b01, 3'd1, 32'h012, 32'hBEEF,     1'b0, 1'b0, 32'h0};
    tbl[19] = '{2'b10, 3'd2, 32'h010, 32'h0,        1'b0, 1'b1, 32'hBEEF5AEF};

    for (int i = 0; i < NB; i++) ref_mem[i] = 8'($urandom);
    rst_n = 1'b0; fill = 1'b1;
    valid = 1'b1; ctrl = 2'b10; f3 = 3'd2; addr = 32'h10; sdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ldata", ld, 32'h0);
    chk("rst.lvalid", 32'(lv), 32'h0);
    chk("rst.fault", 32'(flt), 32'h0);
    chk("rst.ctrl", 32'(mctrl), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; fill = 1'b0; valid = 1'b0;

    for (int i = 0; i < 20; i++)
      do_op(1'b1, tbl[i].c, tbl[i].f, tbl[i].a, tbl[i].d, tbl[i].xf, tbl[i].xlv, tbl[i].xld,
            $sformatf("row%0d", i));

    // reset lands while the merged word is on the bus: the write must be dropped
    do_op(1'b1, 2'b01, 3'd2, 32'h30, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h0, "rmw_pre");
    @(negedge clk);
    valid = 1'b1; ctrl = 2'b01; f3 = 3'd1; addr = 32'h30; sdata = 32'h1234;
    #1;
    chk("rmwrst.stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("rmwrst.in_rmw", 32'(mctrl), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmwrst.ctrl_in_rst", 32'(mctrl), 32'd0);
    @(posedge clk); #1;
    chk("rmwrst.ldata", ld, 32'h0);
    chk("rmwrst.pulses", {30'd0, lv, flt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    #1;
    chk("rmwrst.idle_ctrl", 32'(mctrl), 32'd0);
    do_op(1'b1, 2'b10, 3'd2, 32'h30, 32'h0, 1'b0, 1'b1, 32'hAAAAAAAA, "rmwrst.readback");

    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 9);
      c = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b00;
      if ($urandom_range(0, 4) != 0) begin
        r = $urandom_range(0, 4);
        f = (r == 3) ? 3'd4 : (r == 4) ? 3'd5 : 3'(r);
      end else f = 3'($urandom);
      a = $urandom_range(0, NB - 1);
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(ADDR_W, 31));
      xf  = v && (c != 2'b00) && m_fault(c, f, a);
      xlv = v && (c == 2'b10) && !xf;
      xld = xlv ? m_load(f, a) : 32'h0;
      do_op(v, c, f, a, $urandom, xf, xlv, xld, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    valid = 1'b0;
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== ref_word(4*i)) bad++;
    chk("mem_final_bad_words", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
